// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide sequencer.
package mdu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } mdu_state_e;

   // rs1 is treated as two's complement for these ops
   function automatic logic is_signed_rs1(mdu_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   // rs2 is treated as two's complement for these ops
   function automatic logic is_signed_rs2(mdu_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Core <-> MDU request/response bundle.
interface mdu_seq_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            kill;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rdata1, rdata2, kill,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, rdata1, rdata2, kill,
      output stall, busy, done, result
   );
endinterface

// File: rtl/mdu_step.sv
// One shift/add (multiply) or shift/trial-subtract (restoring divide) step.
// Multiply: acc = {carry, hi, multiplier}; add operand to hi when acc[0], shift right.
// Divide:   acc = {rem[32:0], dividend/quotient}; shift left, subtract operand
//           from the remainder when it fits. The quotient bit is returned
//           separately and the caller merges it into acc[0].
module mdu_step #(
   parameter int XLEN = 32
) (
   input  logic              i_is_div,
   input  logic [2*XLEN:0]   i_acc,
   input  logic [XLEN-1:0]   i_op,
   output logic [2*XLEN:0]   o_acc,
   output logic              o_qbit
);

   logic [XLEN:0]   w_sum;
   logic [2*XLEN:0] w_sh;
   logic [XLEN+1:0] w_diff;
   logic            w_fits;

   // single combinational iteration for either operation
   always_comb begin
      // hi half plus carry bit stays below 2^(XLEN+1), so no overflow here
      w_sum  = i_acc[2*XLEN:XLEN] + (i_acc[0] ? {1'b0, i_op} : '0);
      w_sh   = {i_acc[2*XLEN-1:0], 1'b0};
      w_diff = {1'b0, w_sh[2*XLEN:XLEN]} - {2'b00, i_op};
      w_fits = ~w_diff[XLEN+1];
      o_qbit = i_is_div & w_fits;
      if (i_is_div)
         o_acc = {(w_fits ? w_diff[XLEN:0] : w_sh[2*XLEN:XLEN]), w_sh[XLEN-1:0]};
      else
         o_acc = {1'b0, w_sum, i_acc[XLEN-1:1]};
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M sequencer: 32 iterations of a shared step, then sign
// fixup and high/low selection. Divide-by-zero and signed overflow finish
// in one cycle without iterating.
module mdu_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic    clk,
   input  logic    rst_n,
   mdu_seq_if.slave bus
);
   import mdu_pkg::*;

   mdu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2*XLEN:0]  r_acc;
   logic [XLEN-1:0]  r_op;     // multiplicand or divisor magnitude
   mdu_op_e          r_fn;
   logic             r_sign1;
   logic             r_sign2;
   logic [XLEN-1:0]  r_result;

   mdu_op_e          w_fn;
   logic             w_is_div;
   logic             w_sign1, w_sign2;
   logic [XLEN-1:0]  w_abs1, w_abs2;
   logic             w_div0, w_ovf, w_special;
   logic [XLEN-1:0]  w_spec_res;
   logic             w_accept;
   logic [2*XLEN:0]  w_step_acc;
   logic             w_qbit;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]  w_quo, w_rem;
   logic [XLEN-1:0]  w_fix;

   assign w_fn     = mdu_op_e'(bus.funct3);
   assign w_is_div = bus.funct3[2];
   assign w_sign1  = is_signed_rs1(w_fn) & bus.rdata1[XLEN-1];
   assign w_sign2  = is_signed_rs2(w_fn) & bus.rdata2[XLEN-1];
   assign w_abs1   = w_sign1 ? -bus.rdata1 : bus.rdata1;
   assign w_abs2   = w_sign2 ? -bus.rdata2 : bus.rdata2;
   assign w_accept = (r_state == IDLE) & bus.start & ~bus.kill;

   // special-case divides resolved straight from the operands
   always_comb begin
      w_div0     = (bus.rdata2 == '0);
      w_ovf      = (w_fn == OP_DIV || w_fn == OP_REM) &&
                   (bus.rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rdata2);
      w_special  = w_is_div & (w_div0 | w_ovf);
      w_spec_res = '0;
      if (!bus.funct3[1])   // DIV/DIVU: quotient
         w_spec_res = w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
      else                  // REM/REMU: remainder
         w_spec_res = w_div0 ? bus.rdata1 : '0;
   end

   mdu_step #(.XLEN(XLEN)) u_step (
      .i_is_div (r_fn[2]),
      .i_acc    (r_acc),
      .i_op     (r_op),
      .o_acc    (w_step_acc),
      .o_qbit   (w_qbit)
   );

   // sign correction and result selection after the last iteration
   always_comb begin
      w_prod = r_acc[2*XLEN-1:0];
      if (r_sign1 ^ r_sign2) w_prod = -w_prod;
      w_quo  = r_acc[XLEN-1:0];
      w_rem  = r_acc[2*XLEN-1:XLEN];
      w_fix  = '0;
      case (r_fn)
         OP_MUL:                       w_fix = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix = (r_sign1 ^ r_sign2) ? -w_quo : w_quo;
         OP_REM, OP_REMU:              w_fix = r_sign1 ? -w_rem : w_rem;
         default:                      w_fix = '0;
      endcase
   end

   // sequencer FSM: kill aborts any in-flight op without touching result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_op     <= '0;
         r_fn     <= OP_MUL;
         r_sign1  <= 1'b0;
         r_sign2  <= 1'b0;
         r_result <= '0;
      end else if (bus.kill && r_state != IDLE) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_fn    <= w_fn;
               r_sign1 <= w_sign1;
               r_sign2 <= w_sign2;
               r_cnt   <= '0;
               // divide iterates on the dividend, multiply on the multiplier
               r_acc   <= {{(XLEN+1){1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
               r_op    <= w_is_div ? w_abs2 : w_abs1;
               if (w_special) begin
                  r_result <= w_spec_res;
                  r_state  <= DONE;
               end else begin
                  r_state  <= ITER;
               end
            end
            ITER: begin
               r_acc <= {w_step_acc[2*XLEN:1], w_step_acc[0] | w_qbit};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(XLEN-1)) r_state <= FIXUP;
            end
            FIXUP: begin
               r_result <= w_fix;
               r_state  <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.stall  = w_accept | (r_state == ITER) | (r_state == FIXUP);
   assign bus.busy   = (r_state != IDLE);
   assign bus.done   = (r_state == DONE);
   assign bus.result = r_result;

endmodule
